mouse_cfg_seq: RTL
==================

// Module: mouse_cfg_seq
// PURPOSE
//  Sequencer that configures the PS/2 mouse controller (MouseCtl) through its shared value bus
//  and its setmax_x/setmax_y/setx/sety write strobes. Runs in the MouseCtl clock domain.
//  Arbitrates three requesters (resolution change, absolute position set, recenter) and
//  programs the default screen size and centre automatically after reset.
// PARAMETERS
//  W         12   width of value bus and all coordinates
//  DEF_MAX_X 799  max_x programmed after reset
//  DEF_MAX_Y 599  max_y programmed after reset
//  GAP       4    idle cycles after each strobe before the next write (0 allowed)
// PORTS
//  clk           in   1  controller clock (same clock as MouseCtl)
//  rst_n         in   1  asynchronous, active-low reset
//  cfg_req       in   1  1-cycle pulse: new resolution; max_x_in/max_y_in sampled with it
//  max_x_in      in   W  new max_x
//  max_y_in      in   W  new max_y
//  setpos_req    in   1  1-cycle pulse: move cursor; pos_x_in/pos_y_in sampled with it
//  pos_x_in      in   W  requested x
//  pos_y_in      in   W  requested y
//  recenter_req  in   1  1-cycle pulse: move cursor to (cur_max_x>>1, cur_max_y>>1)
//  value         out  W  data to MouseCtl value input; held through strobe and gap cycles
//  setmax_x      out  1  1-cycle write strobe, max_x
//  setmax_y      out  1  1-cycle write strobe, max_y
//  setx          out  1  1-cycle write strobe, x
//  sety          out  1  1-cycle write strobe, y
//  busy          out  1  high while a sequence is in progress
//  done          out  1  1-cycle pulse when a sequence completes
//  cur_max_x     out  W  max_x last written to MouseCtl
//  cur_max_y     out  W  max_y last written to MouseCtl
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, all registers cleared, init_pend=1, state IDLE;
//    aborts any sequence immediately. All outputs registered.
//  - States: IDLE, WR_MAXX, WR_MAXY, WR_X, WR_Y, WAIT (gap counter), DONE.
//  - Each write: strobe high exactly 1 cycle with value valid; then GAP cycles with all strobes 0
//    and value held. Exactly one strobe high in any cycle.
//  - Sequences: INIT = MAXX(DEF_MAX_X), MAXY(DEF_MAX_Y), X(DEF_MAX_X>>1), Y(DEF_MAX_Y>>1).
//    CFG = MAXX(max_x_in), MAXY(max_y_in), X(max_x_in>>1), Y(max_y_in>>1).
//    SETPOS = X(min(pos_x_in,cur_max_x)), Y(min(pos_y_in,cur_max_y)); clamp uses cur_max at launch.
//    RECENTER = X(cur_max_x>>1), Y(cur_max_y>>1).
//  - cur_max_x/y update in the cycle their strobe is driven.
//  - Requests set sticky pending flags + latch data; a later request of same kind overwrites data.
//  - Launch in IDLE (or DONE cycle) on pending|req: priority INIT > CFG > SETPOS > RECENTER.
//    Starting INIT or CFG clears recenter_pend; starting SETPOS clears recenter_pend.
//    setpos_pend survives a CFG launch and runs afterwards (clamped to new max).
//  - Latency: request in cycle n while idle -> first strobe in cycle n+1.
//    4-write seq: strobes n+1, n+1+(GAP+1), ... ; done at n+1+4*(GAP+1). 2-write: n+1+2*(GAP+1).
//  - busy high from first strobe cycle through last gap cycle; low in done cycle.
//  - done cycle acts as IDLE: pending work launches there, next strobe in done+1.
//  - INIT behaves as a request in cycle 0 = first cycle with rst_n high.
//  - max_x_in=0 legal: centre 0, later positions clamp to 0.
// TESTING
//  1 Reset release, defaults -> setmax_x val 799 @1, setmax_y 599 @6, setx 399 @11,
//    sety 299 @16, done @21; cur_max=799/599; busy 1..20.
//  2 Idle, setpos_req (1000,50) @n -> setx val 799 @n+1, sety val 50 @n+6, done @n+11.
//  3 cfg_req (1023,767) @5 during INIT -> pending; setmax_x 1023 @22, setx 511 @32,
//    sety 383 @37, done @42.
//  4 Idle, cfg(639,479)+setpos(700,10)+recenter same cycle n -> CFG runs (done n+21), SETPOS
//    strobes from n+22 with x 639, y 10; no recenter sequence.
//  5 rst_n low mid-WR_MAXY -> outputs 0 same cycle (async); after release INIT restarts as test 1.
//  6 GAP=0, recenter_req idle -> setx and sety in consecutive cycles n+1,n+2; done n+3.

Source files
------------

// File: rtl/mouse_cfg_seq.sv
// Purpose: sequences MouseCtl value/strobe writes for the reset defaults, resolution changes, cursor moves and recenter.
// Latency: a request seen while idle (or in the done cycle) produces its first strobe on the next cycle; each write takes 1+GAP cycles.
// Backpressure: none toward requesters; requests arriving while busy stay pending (newest data wins) and launch in priority order.
module mouse_cfg_seq #(
  parameter int W         = 12,
  parameter int DEF_MAX_X = 799,
  parameter int DEF_MAX_Y = 599,
  parameter int GAP       = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_req,
  input  logic [W-1:0] max_x_in,
  input  logic [W-1:0] max_y_in,
  input  logic         setpos_req,
  input  logic [W-1:0] pos_x_in,
  input  logic [W-1:0] pos_y_in,
  input  logic         recenter_req,
  output logic [W-1:0] value,
  output logic         setmax_x,
  output logic         setmax_y,
  output logic         setx,
  output logic         sety,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] cur_max_x,
  output logic [W-1:0] cur_max_y
);

  localparam logic [W-1:0] DEF_X  = W'(DEF_MAX_X);
  localparam logic [W-1:0] DEF_Y  = W'(DEF_MAX_Y);
  localparam int           CW     = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int           GAP_M1 = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_M1);

  typedef enum logic [2:0] {
    IDLE, WR_MAXX, WR_MAXY, WR_X, WR_Y, WAIT, DONE
  } state_t;

  state_t        state_q, state_d, nxt_q, nxt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pending request flags and their latched operands
  logic          init_pend, init_pend_d;
  logic          cfg_pend, cfg_pend_d, sp_pend, sp_pend_d, rc_pend, rc_pend_d;
  logic [W-1:0]  cfg_x_q, cfg_x_d, cfg_y_q, cfg_y_d;
  logic [W-1:0]  sp_x_q, sp_x_d, sp_y_q, sp_y_d;

  // Operands of the sequence currently running, fixed at launch
  logic [W-1:0]  seq_mx, seq_mx_d, seq_my, seq_my_d, seq_x, seq_x_d, seq_y, seq_y_d;

  // Next-cycle values of the registered outputs
  logic [W-1:0]  value_d, cur_max_x_d, cur_max_y_d;
  logic          setmax_x_d, setmax_y_d, setx_d, sety_d, busy_d, done_d;

  logic          adv, finish;
  state_t        tgt, follow;

  // State, pending flags, sequence operands and all outputs register here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      nxt_q     <= IDLE;
      cnt_q     <= '0;
      init_pend <= 1'b1;
      cfg_pend  <= 1'b0;
      sp_pend   <= 1'b0;
      rc_pend   <= 1'b0;
      cfg_x_q   <= '0;
      cfg_y_q   <= '0;
      sp_x_q    <= '0;
      sp_y_q    <= '0;
      seq_mx    <= '0;
      seq_my    <= '0;
      seq_x     <= '0;
      seq_y     <= '0;
      value     <= '0;
      setmax_x  <= 1'b0;
      setmax_y  <= 1'b0;
      setx      <= 1'b0;
      sety      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_max_x <= '0;
      cur_max_y <= '0;
    end else begin
      state_q   <= state_d;
      nxt_q     <= nxt_d;
      cnt_q     <= cnt_d;
      init_pend <= init_pend_d;
      cfg_pend  <= cfg_pend_d;
      sp_pend   <= sp_pend_d;
      rc_pend   <= rc_pend_d;
      cfg_x_q   <= cfg_x_d;
      cfg_y_q   <= cfg_y_d;
      sp_x_q    <= sp_x_d;
      sp_y_q    <= sp_y_d;
      seq_mx    <= seq_mx_d;
      seq_my    <= seq_my_d;
      seq_x     <= seq_x_d;
      seq_y     <= seq_y_d;
      value     <= value_d;
      setmax_x  <= setmax_x_d;
      setmax_y  <= setmax_y_d;
      setx      <= setx_d;
      sety      <= sety_d;
      busy      <= busy_d;
      done      <= done_d;
      cur_max_x <= cur_max_x_d;
      cur_max_y <= cur_max_y_d;
    end
  end

  // Request capture, launch arbitration, write/gap sequencing and next outputs
  always_comb begin
    state_d     = state_q;
    nxt_d       = nxt_q;
    cnt_d       = cnt_q;
    value_d     = value;
    setmax_x_d  = 1'b0;
    setmax_y_d  = 1'b0;
    setx_d      = 1'b0;
    sety_d      = 1'b0;
    busy_d      = busy;
    done_d      = 1'b0;
    cur_max_x_d = cur_max_x;
    cur_max_y_d = cur_max_y;
    seq_mx_d    = seq_mx;
    seq_my_d    = seq_my;
    seq_x_d     = seq_x;
    seq_y_d     = seq_y;
    adv         = 1'b0;
    finish      = 1'b0;
    tgt         = IDLE;
    follow      = DONE;

    // A request in this cycle counts as pending immediately; newest data overwrites
    init_pend_d = init_pend;
    cfg_pend_d  = cfg_pend | cfg_req;
    cfg_x_d     = cfg_req ? max_x_in : cfg_x_q;
    cfg_y_d     = cfg_req ? max_y_in : cfg_y_q;
    sp_pend_d   = sp_pend | setpos_req;
    sp_x_d      = setpos_req ? pos_x_in : sp_x_q;
    sp_y_d      = setpos_req ? pos_y_in : sp_y_q;
    rc_pend_d   = rc_pend | recenter_req;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (init_pend) begin
          seq_mx_d    = DEF_X;
          seq_my_d    = DEF_Y;
          seq_x_d     = DEF_X >> 1;
          seq_y_d     = DEF_Y >> 1;
          init_pend_d = 1'b0;
          rc_pend_d   = 1'b0;
          adv         = 1'b1;
          tgt         = WR_MAXX;
        end else if (cfg_pend_d) begin
          seq_mx_d   = cfg_x_d;
          seq_my_d   = cfg_y_d;
          seq_x_d    = cfg_x_d >> 1;
          seq_y_d    = cfg_y_d >> 1;
          cfg_pend_d = 1'b0;
          rc_pend_d  = 1'b0;
          adv        = 1'b1;
          tgt        = WR_MAXX;
        end else if (sp_pend_d) begin
          // Clamp against the limits in force right now, i.e. after any CFG that just finished
          seq_x_d   = (sp_x_d > cur_max_x) ? cur_max_x : sp_x_d;
          seq_y_d   = (sp_y_d > cur_max_y) ? cur_max_y : sp_y_d;
          sp_pend_d = 1'b0;
          rc_pend_d = 1'b0;
          adv       = 1'b1;
          tgt       = WR_X;
        end else if (rc_pend_d) begin
          seq_x_d   = cur_max_x >> 1;
          seq_y_d   = cur_max_y >> 1;
          rc_pend_d = 1'b0;
          adv       = 1'b1;
          tgt       = WR_X;
        end
      end
      WR_MAXX, WR_MAXY, WR_X, WR_Y: begin
        case (state_q)
          WR_MAXX: follow = WR_MAXY;
          WR_MAXY: follow = WR_X;
          WR_X:    follow = WR_Y;
          default: follow = DONE;
        endcase
        if (GAP == 0) begin
          if (follow == DONE) begin
            finish = 1'b1;
          end else begin
            adv = 1'b1;
            tgt = follow;
          end
        end else begin
          state_d = WAIT;
          cnt_d   = GAP_LD;
          nxt_d   = follow;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (nxt_q == DONE) begin
            finish = 1'b1;
          end else begin
            adv = 1'b1;
            tgt = nxt_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
    end

    // Entering a write state: raise its strobe and present its value next cycle
    if (adv) begin
      state_d = tgt;
      busy_d  = 1'b1;
      case (tgt)
        WR_MAXX: begin
          setmax_x_d  = 1'b1;
          value_d     = seq_mx_d;
          cur_max_x_d = seq_mx_d;
        end
        WR_MAXY: begin
          setmax_y_d  = 1'b1;
          value_d     = seq_my_d;
          cur_max_y_d = seq_my_d;
        end
        WR_X: begin
          setx_d  = 1'b1;
          value_d = seq_x_d;
        end
        WR_Y: begin
          sety_d  = 1'b1;
          value_d = seq_y_d;
        end
        default: ;
      endcase
    end
  end

endmodule
